fdiv_iter: RTL and testbench

- Single-precision floating-point divider, y = x1 / x2. It is the inverse-direction companion of the combinational multiplier in the FPU.
- Uses the same numeric conventions as the multiplier:
  - subnormals are flushed to zero;
  - the mantissa is truncated, with no rounding;
  - no NaN propagation.
- Iterative radix-2 restoring divider that produces one quotient bit per cycle.
- Connects to the FPU issue and writeback paths through a valid/ready handshake on the input side and on the output side.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fdiv_step.sv | 25 ++
 rtl/fdiv_iter.sv | 117 +++++++++++
 tb/tb_fdiv_iter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field layout, divider FSM
// states and field-extract helpers used by fmul and fdiv_iter.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic logic f_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [31:0] v);
    return v[22:0];
  endfunction

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division step: compare, subtract, shift.
// R stays below 2*M2, so bit 25 is always zero before the shift.
module fdiv_step
  import fpu_pkg::*;
(
  input  logic [25:0] i_r,
  input  logic [23:0] i_m2,
  output logic [25:0] o_r_next,
  output logic        o_q_bit
);

  logic [25:0] w_diff;
  logic        w_ge;

  assign w_ge = (i_r >= {2'b00, i_m2});
  assign w_diff = i_r - {2'b00, i_m2};

  // subtract when the divisor fits, then shift left
  always_comb begin
    o_q_bit = w_ge;
    o_r_next = w_ge ? {w_diff[24:0], 1'b0}
                    : {i_r[24:0], 1'b0};
  end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative binary32 divider, one quotient bit per cycle.
// FTZ, truncating, valid/ready on both sides.
module fdiv_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t             r_state;
  logic        [4:0]  r_cnt;
  logic        [25:0] r_rem;
  logic        [23:0] r_m2;
  logic        [21:0] r_q;
  logic               r_sy;
  logic signed [9:0]  r_exp;
  logic        [31:0] r_y;
  logic               r_out_valid;

  logic        [23:0] w_m1;
  logic        [23:0] w_m2;
  logic               w_sy;
  logic               w_adj;
  logic signed [9:0]  w_exp;
  logic        [25:0] w_r_next;
  logic               w_q_bit;

  assign w_m1 = {1'b1, f_man(x1)};
  assign w_m2 = {1'b1, f_man(x2)};
  assign w_sy = f_sign(x1) ^ f_sign(x2);
  assign w_adj = (w_m1 < w_m2);
  assign w_exp = $signed({2'b00, f_exp(x1)})
               - $signed({2'b00, f_exp(x2)})
               + 10'sd127
               - $signed({9'd0, w_adj});

  assign in_ready = (r_state == IDLE);
  assign y = r_y;
  assign out_valid = r_out_valid;

  fdiv_step u_step (
    .i_r      (r_rem),
    .i_m2     (r_m2),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  // accept / iterate / hold-result state machine
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rem <= '0;
      r_m2 <= '0;
      r_q <= '0;
      r_sy <= 1'b0;
      r_exp <= '0;
      r_y <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sy <= w_sy;
            r_m2 <= w_m2;
            r_exp <= w_exp;
            r_cnt <= '0;
            r_q <= '0;
            r_rem <= w_adj ? {1'b0, w_m1, 1'b0}
                           : {2'b00, w_m1};
            if (f_exp(x1) == '0) begin
              r_y <= {w_sy, 31'd0};
              r_out_valid <= 1'b1;
              r_state <= DONE;
            end else if (f_exp(x2) == '0) begin
              r_y <= {w_sy, EXP_MAX, 23'd0};
              r_out_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          r_rem <= w_r_next;
          r_q <= {r_q[20:0], w_q_bit};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            r_state <= DONE;
            r_out_valid <= 1'b1;
            if (r_exp <= 10'sd0)
              r_y <= {r_sy, 31'd0};
            else if (r_exp >= 10'sd255)
              r_y <= {r_sy, EXP_MAX, 23'd0};
            else
              r_y <= {r_sy, r_exp[7:0], r_q, w_q_bit};
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: vector table plus
// backpressure, back-to-back and mid-operation reset.
module tb_fdiv_iter;

  logic        clk;
  logic        rstn;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  fdiv_iter dut (
    .clk       (clk),
    .rstn      (rstn),
    .x1        (x1),
    .x2        (x2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // lat counts edges from the accepting edge (that edge = 1)
  task automatic start_op(input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_before", {31'd0, in_ready}, 32'd1);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x1 = 32'hDEADBEEF;
    x2 = 32'h12345678;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid never rose");
    end
  endtask

  task automatic release_out(input logic [31:0] held);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ov_after_hs", {31'd0, out_valid}, 32'd0);
    chk("ir_after_hs", {31'd0, in_ready}, 32'd1);
    chk("y_kept", y, held);
  endtask

  int lat;

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    x1 = '0;
    x2 = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 25};
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 25};
    vecs[2] = '{32'hBF800000, 32'h3F000000, 32'hC0000000, 25};
    vecs[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1};
    vecs[4] = '{32'h80000000, 32'h40000000, 32'h80000000, 1};
    vecs[5] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 25};
    vecs[6] = '{32'h00800000, 32'h40000000, 32'h00000000, 25};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("y_v%0d", i), y, vecs[i].q);
      chk($sformatf("lat_v%0d", i), lat, vecs[i].lat);
      chk($sformatf("ir_done_v%0d", i),
          {31'd0, in_ready}, 32'd0);
      release_out(vecs[i].q);
    end

    start_op(32'h40C00000, 32'h40000000);
    wait_done(lat);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_y", y, 32'h40400000);
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_ir", {31'd0, in_ready}, 32'd0);
    end
    release_out(32'h40400000);
    start_op(32'h3F800000, 32'h40400000);
    wait_done(lat);
    chk("b2b_y", y, 32'h3EAAAAAA);
    chk("b2b_lat", lat, 25);
    release_out(32'h3EAAAAAA);

    start_op(32'h3F800000, 32'h40400000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_ov", {31'd0, out_valid}, 32'd0);
    chk("mrst_y", y, 32'd0);
    chk("mrst_ir", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    start_op(32'h40C00000, 32'h40000000);
    wait_done(lat);
    chk("mrst_res", y, 32'h40400000);
    chk("mrst_lat", lat, 25);
    release_out(32'h40400000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
